// File: rtl/seq_pkg.sv
// seq_pkg: shared types and defaults for the run reporter.
// Optional field ts is present when SEQ_REPORT_TIMESTAMP_EN is defined.
package seq_pkg;

   localparam int MIN_RUN   = 4;
   localparam int DEPTH_DEF = 4;
   localparam int LEN_W_DEF = 8;
   localparam int CNT_W_DEF = 16;
   localparam int TS_W_DEF  = 16;

   typedef enum logic {IDLE, RUN} state_t;

   // Record layout at the default widths; the top builds the same shape from its own parameters.
   typedef struct packed {
      logic                 pattern;
      logic [LEN_W_DEF-1:0] len;
`ifdef SEQ_REPORT_TIMESTAMP_EN
      logic [TS_W_DEF-1:0]  ts;
`endif
   } rec_t;

endpackage

// File: rtl/seq_report_fifo.sv
// seq_report_fifo: synchronous FIFO with extra-MSB pointers; head reads as 0 when empty.
module seq_report_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wp_q, rp_q;
   logic         do_pop, do_push;

   assign empty_o = wp_q == rp_q;
   assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign dout_o  = empty_o ? '0 : mem_q[rp_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + 1'b1;
         if (do_pop)  rp_q <= rp_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/seq_run_reporter.sv
// seq_run_reporter: turns each detector run into a {pattern,len} record queued behind valid/ready.
// SEQ_REPORT_TIMESTAMP_EN adds a free-running cycle counter sampled at run start (rep_ts).
module seq_run_reporter
   import seq_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int LEN_W = LEN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
`ifdef SEQ_REPORT_TIMESTAMP_EN
   , parameter int TS_W = TS_W_DEF
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             w,
   input  logic             z,
   output logic             rep_valid,
   input  logic             rep_ready,
   output logic             rep_pattern,
   output logic [LEN_W-1:0] rep_len,
   output logic [CNT_W-1:0] event_count,
   output logic             overflow,
`ifdef SEQ_REPORT_TIMESTAMP_EN
   output logic [TS_W-1:0]  rep_ts,
`endif
   input  logic             clr_ovf
);

   typedef struct packed {
      logic             pattern;
      logic [LEN_W-1:0] len;
`ifdef SEQ_REPORT_TIMESTAMP_EN
      logic [TS_W-1:0]  ts;
`endif
   } rec_p_t;

   state_t           state_q;
   logic             w_q, z_q, pat_q, ovf_q, ovf_d;
   logic [LEN_W-1:0] len_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push, pop, drop, full, empty;
   rec_p_t           rec_in, rec_out;
`ifdef SEQ_REPORT_TIMESTAMP_EN
   logic [TS_W-1:0]  ts_cnt_q, ts_q;
`endif

   assign push  = (state_q == RUN) & ~z;
   assign pop   = rep_ready & ~empty;
   assign drop  = push & full & ~pop;
   assign cnt_d = push ? cnt_q + 1'b1 : cnt_q;
   assign ovf_d = drop | (ovf_q & ~clr_ovf);

   assign rec_in = {pat_q, len_q
`ifdef SEQ_REPORT_TIMESTAMP_EN
                    , ts_q
`endif
                   };

   // z_q resets high so a run already in progress at reset release is never mistaken for a new one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         w_q     <= 1'b0;
         z_q     <= 1'b1;
         pat_q   <= 1'b0;
         len_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
`ifdef SEQ_REPORT_TIMESTAMP_EN
         ts_cnt_q <= '0;
         ts_q     <= '0;
`endif
      end else begin
         w_q   <= w;
         z_q   <= z;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
`ifdef SEQ_REPORT_TIMESTAMP_EN
         ts_cnt_q <= ts_cnt_q + 1'b1;
`endif
         if (state_q == IDLE) begin
            if (z && !z_q) begin
               state_q <= RUN;
               pat_q   <= w_q;
               len_q   <= LEN_W'(MIN_RUN);
`ifdef SEQ_REPORT_TIMESTAMP_EN
               ts_q    <= ts_cnt_q;
`endif
            end
         end else if (z) begin
            len_q <= (len_q == '1) ? len_q : len_q + 1'b1;
         end else begin
            state_q <= IDLE;
         end
      end
   end

   seq_report_fifo #(.DEPTH(DEPTH), .W($bits(rec_p_t))) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push & ~drop),
      .pop_i   (pop),
      .din_i   (rec_in),
      .dout_o  (rec_out),
      .full_o  (full),
      .empty_o (empty)
   );

   assign rep_valid   = ~empty;
   assign rep_pattern = rec_out.pattern;
   assign rep_len     = rec_out.len;
   assign event_count = cnt_q;
   assign overflow    = ovf_q;
`ifdef SEQ_REPORT_TIMESTAMP_EN
   assign rep_ts      = rec_out.ts;
`endif

endmodule
